// File: rtl/conn_box_mp.sv
// Connection box: W routing tracks x P logic-block pins through bidirectional tristate buffers.
// The configuration is scanned into a shadow register, screened for drive conflicts and committed atomically.
module conn_box_mp #(
  parameter  int W         = 4,
  parameter  int P         = 2,
  localparam int CHAIN_LEN = 2 * W * P,
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  inout  wire  [W-1:0] a,
  inout  wire  [P-1:0] b,
  input  logic         si,
  input  logic         se,
  input  logic         commit,
  output logic         so,
  output logic         cfg_ready,
  output logic         cfg_ack,
  output logic         cfg_err
);

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_LOADING = 2'd1,
    S_READY   = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);

  state_e               state_q, state_d;
  logic [CHAIN_LEN-1:0] shadow_q, shadow_d;
  logic [CHAIN_LEN-1:0] active_q, active_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;
  logic                 conflict;
  logic                 accept;

  logic [P-1:0]         b_oe, b_out;
  logic [W-1:0]         a_oe, a_out;

  // Cell (t,p) lives at en = bit p*2W+t, dir = bit p*2W+W+t of a configuration image.
  always_comb begin : conflict_check
    logic         pin_seen;
    logic [W-1:0] trk_seen;
    conflict = 1'b0;
    pin_seen = 1'b0;
    trk_seen = '0;
    for (int p = 0; p < P; p++) begin
      pin_seen = 1'b0;
      for (int t = 0; t < W; t++) begin
        if (shadow_q[p*2*W + t]) begin
          if (shadow_q[p*2*W + W + t]) begin
            if (pin_seen) conflict = 1'b1;
            pin_seen = 1'b1;
          end else begin
            if (trk_seen[t]) conflict = 1'b1;
            trk_seen[t] = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    ack_d    = 1'b0;
    err_d    = err_q;
    accept   = commit && !se && (cnt_q == CNT_FULL) && !conflict;
    if (se) begin
      shadow_d = {shadow_q[CHAIN_LEN-2:0], si};
      if (cnt_q != CNT_FULL) cnt_d = cnt_q + 1'b1;
    end
    // A commit is judged every cycle it is high; anything but a clean accept is sticky-flagged.
    if (commit) begin
      if (accept) begin
        active_d = shadow_q;
        cnt_d    = '0;
        ack_d    = 1'b1;
        err_d    = 1'b0;
      end else begin
        err_d    = 1'b1;
      end
    end
    if (cnt_d == '0)           state_d = S_EMPTY;
    else if (cnt_d == CNT_FULL) state_d = S_READY;
    else                       state_d = S_LOADING;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_EMPTY;
      shadow_q <= '0;
      active_q <= '0;
      cnt_q    <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
    end
  end

  assign so        = shadow_q[CHAIN_LEN-1];
  assign cfg_ready = (state_q == S_READY);
  assign cfg_ack   = ack_q;
  assign cfg_err   = err_q;

  // Buffers are enabled only from the committed image, so a reset releases them immediately.
  always_comb begin
    b_oe  = '0;
    b_out = '0;
    for (int p = 0; p < P; p++) begin
      for (int t = 0; t < W; t++) begin
        if (active_q[p*2*W + t] && active_q[p*2*W + W + t]) begin
          b_oe[p]  = 1'b1;
          b_out[p] = b_out[p] | a[t];
        end
      end
    end
  end

  always_comb begin
    a_oe  = '0;
    a_out = '0;
    for (int t = 0; t < W; t++) begin
      for (int p = 0; p < P; p++) begin
        if (active_q[p*2*W + t] && !active_q[p*2*W + W + t]) begin
          a_oe[t]  = 1'b1;
          a_out[t] = a_out[t] | b[p];
        end
      end
    end
  end

  for (genvar gp = 0; gp < P; gp++) begin : g_pin
    assign b[gp] = b_oe[gp] ? b_out[gp] : 1'bz;
  end

  for (genvar gt = 0; gt < W; gt++) begin : g_trk
    assign a[gt] = a_oe[gt] ? a_out[gt] : 1'bz;
  end

endmodule

// File: tb/tb_conn_box_mp.sv
// Randomized bench for conn_box_mp: a bit-history/image model predicts scan-out, commit outcome and net values.
module tb_conn_box_mp;

  localparam int W  = 4;
  localparam int P  = 2;
  localparam int CL = 2 * W * P;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic si     = 1'b0;
  logic se     = 1'b0;
  logic commit = 1'b0;
  wire  [W-1:0] a;
  wire  [P-1:0] b;
  logic so, cfg_ready, cfg_ack, cfg_err;

  logic [W-1:0] ta_oe  = '0;
  logic [W-1:0] ta_val = '0;
  logic [P-1:0] tp_oe  = '0;
  logic [P-1:0] tp_val = '0;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: every bit ever shifted since reset, bits since last accepted commit, committed image, error flag.
  bit             hist[$];
  int             m_cnt    = 0;
  logic [CL-1:0]  m_active = '0;
  logic           m_err    = 1'b0;

  for (genvar i = 0; i < W; i++) begin : g_a
    assign a[i] = ta_oe[i] ? ta_val[i] : 1'bz;
    pulldown pd_a (a[i]);
  end
  for (genvar i = 0; i < P; i++) begin : g_b
    assign b[i] = tp_oe[i] ? tp_val[i] : 1'bz;
    pulldown pd_b (b[i]);
  end

  conn_box_mp #(.W(W), .P(P)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .si        (si),
    .se        (se),
    .commit    (commit),
    .so        (so),
    .cfg_ready (cfg_ready),
    .cfg_ack   (cfg_ack),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [CL-1:0] m_shadow();
    logic [CL-1:0] s;
    int n;
    s = '0;
    n = hist.size();
    for (int i = 0; i < CL && i < n; i++) s[i] = hist[n-1-i];
    return s;
  endfunction

  function automatic logic exp_so();
    int n;
    n = hist.size();
    return (n >= CL) ? logic'(hist[n-CL]) : 1'b0;
  endfunction

  function automatic bit has_conflict(input logic [CL-1:0] img);
    int drv;
    for (int p = 0; p < P; p++) begin
      drv = 0;
      for (int t = 0; t < W; t++) if (img[p*2*W+t] && img[p*2*W+W+t]) drv++;
      if (drv > 1) return 1'b1;
    end
    for (int t = 0; t < W; t++) begin
      drv = 0;
      for (int p = 0; p < P; p++) if (img[p*2*W+t] && !img[p*2*W+W+t]) drv++;
      if (drv > 1) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Each pin is unused, fed by one track, or feeding some tracks; no track serves two roles.
  function automatic logic [CL-1:0] gen_valid();
    logic [CL-1:0] img;
    logic [W-1:0]  used;
    int mode, t;
    img  = '0;
    used = '0;
    for (int p = 0; p < P; p++) begin
      mode = $urandom_range(0, 2);
      if (mode == 1) begin
        t = $urandom_range(0, W-1);
        if (!used[t]) begin
          img[p*2*W+t]   = 1'b1;
          img[p*2*W+W+t] = 1'b1;
          used[t]        = 1'b1;
        end
      end else if (mode == 2) begin
        for (int k = 0; k < W; k++) begin
          if (!used[k] && $urandom_range(0, 1) == 1) begin
            img[p*2*W+k] = 1'b1;
            used[k]      = 1'b1;
          end
        end
      end
    end
    for (int p = 0; p < P; p++)
      for (int k = 0; k < W; k++)
        if (!img[p*2*W+k]) img[p*2*W+W+k] = 1'($urandom_range(0, 1));
    return img;
  endfunction

  function automatic logic [CL-1:0] gen_conflict();
    logic [CL-1:0] img;
    int p, t1, t2, t, p1, p2;
    img = gen_valid();
    if ($urandom_range(0, 1) == 1) begin
      p  = $urandom_range(0, P-1);
      t1 = $urandom_range(0, W-1);
      t2 = (t1 + 1 + $urandom_range(0, W-2)) % W;
      img[p*2*W+t1] = 1'b1; img[p*2*W+W+t1] = 1'b1;
      img[p*2*W+t2] = 1'b1; img[p*2*W+W+t2] = 1'b1;
    end else begin
      t  = $urandom_range(0, W-1);
      p1 = $urandom_range(0, P-1);
      p2 = (p1 + 1) % P;
      img[p1*2*W+t] = 1'b1; img[p1*2*W+W+t] = 1'b0;
      img[p2*2*W+t] = 1'b1; img[p2*2*W+W+t] = 1'b0;
    end
    return img;
  endfunction

  // mode 0: drive every undriven-by-DUT net randomly; 1: tracks only at 1; 2: pins only at 1.
  task automatic check_nets(input int mode);
    int src_pin[P];
    int src_trk[W];
    logic [W-1:0] base_a, exp_a;
    logic [P-1:0] base_b, exp_b;
    for (int p = 0; p < P; p++) begin
      src_pin[p] = -1;
      for (int t = 0; t < W; t++) if (m_active[p*2*W+t] && m_active[p*2*W+W+t]) src_pin[p] = t;
    end
    for (int t = 0; t < W; t++) begin
      src_trk[t] = -1;
      for (int p = 0; p < P; p++) if (m_active[p*2*W+t] && !m_active[p*2*W+W+t]) src_trk[t] = p;
    end
    ta_oe = '0; tp_oe = '0;
    for (int t = 0; t < W; t++) begin
      ta_val[t] = (mode == 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (src_trk[t] < 0) ta_oe[t] = (mode != 2);
      base_a[t] = ta_oe[t] ? ta_val[t] : 1'b0;
    end
    for (int p = 0; p < P; p++) begin
      tp_val[p] = (mode == 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (src_pin[p] < 0) tp_oe[p] = (mode != 1);
      base_b[p] = tp_oe[p] ? tp_val[p] : 1'b0;
    end
    for (int t = 0; t < W; t++) exp_a[t] = (src_trk[t] >= 0) ? base_b[src_trk[t]] : base_a[t];
    for (int p = 0; p < P; p++) exp_b[p] = (src_pin[p] >= 0) ? base_a[src_pin[p]] : base_b[p];
    #1;
    check($sformatf("tracks_m%0d", mode), 32'(a), 32'(exp_a));
    check($sformatf("pins_m%0d", mode), 32'(b), 32'(exp_b));
    ta_oe = '0;
    tp_oe = '0;
  endtask

  task automatic do_shift(input bit v);
    si = v; se = 1'b1;
    @(posedge clk); #1;
    se = 1'b0; si = 1'b0;
    hist.push_back(v);
    if (m_cnt < CL) m_cnt++;
    check("so", 32'(so), 32'(exp_so()));
    check("ready", 32'(cfg_ready), 32'(m_cnt == CL));
  endtask

  task automatic shift_image(input logic [CL-1:0] img);
    for (int i = CL-1; i >= 0; i--) do_shift(img[i]);
  endtask

  task automatic do_commit(input bit with_se);
    logic [CL-1:0] sh;
    bit acc, v;
    sh  = m_shadow();
    v   = 1'($urandom_range(0, 1));
    acc = !with_se && (m_cnt == CL) && !has_conflict(sh);
    commit = 1'b1; se = with_se; si = v;
    @(posedge clk); #1;
    commit = 1'b0; se = 1'b0; si = 1'b0;
    if (with_se) begin
      hist.push_back(v);
      if (m_cnt < CL) m_cnt++;
    end
    if (acc) begin
      m_active = sh; m_cnt = 0; m_err = 1'b0;
    end else begin
      m_err = 1'b1;
    end
    check("ack", 32'(cfg_ack), 32'(acc));
    check("err", 32'(cfg_err), 32'(m_err));
    check("ready_c", 32'(cfg_ready), 32'(m_cnt == CL));
    check("so_c", 32'(so), 32'(exp_so()));
    check_nets(0);
    @(posedge clk); #1;
    check("ack_clr", 32'(cfg_ack), 32'd0);
    check("so_hold", 32'(so), 32'(exp_so()));
    check_nets(1);
    check_nets(2);
  endtask

  initial begin
    logic [CL-1:0] img;
    int n, act;

    // Reset values and released buffers.
    repeat (2) @(posedge clk);
    #1;
    check("rst_so", 32'(so), 32'd0);
    check("rst_ready", 32'(cfg_ready), 32'd0);
    check("rst_ack", 32'(cfg_ack), 32'd0);
    check("rst_err", 32'(cfg_err), 32'd0);
    check_nets(1);
    check_nets(2);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Track 0 onto pin 0.
    shift_image(16'h0011);
    do_commit(1'b0);

    // Two tracks onto pin 0 is refused; previous routing survives.
    shift_image(16'h0033);
    do_commit(1'b0);
    shift_image(16'h0011);
    do_commit(1'b0);

    // Commit after 10 bits is refused, after 16 it is taken.
    img = 16'h2104;
    for (int i = CL-1; i >= 6; i--) do_shift(img[i]);
    do_commit(1'b0);
    for (int i = 5; i >= 0; i--) do_shift(img[i]);
    do_commit(1'b0);

    // Shift and commit together: shift happens, commit refused.
    shift_image(16'h0011);
    do_commit(1'b1);

    // Reset dropped in the middle of a load.
    shift_image(16'h0011);
    do_commit(1'b0);
    for (int i = 0; i < 8; i++) do_shift(1'($urandom_range(0, 1)));
    do_commit(1'b0);
    #2;
    rst_n = 1'b0;
    hist.delete();
    m_cnt = 0; m_active = '0; m_err = 1'b0;
    #1;
    check("mid_rst_so", 32'(so), 32'd0);
    check("mid_rst_ready", 32'(cfg_ready), 32'd0);
    check("mid_rst_ack", 32'(cfg_ack), 32'd0);
    check("mid_rst_err", 32'(cfg_err), 32'd0);
    check_nets(1);
    check_nets(2);
    @(posedge clk); #1;
    rst_n = 1'b1;
    shift_image(gen_valid());
    do_commit(1'b0);
    for (int i = 0; i < CL; i++) do_shift(1'($urandom_range(0, 1)));

    // Randomized mix of loads and commit attempts.
    repeat (40) begin
      act = $urandom_range(0, 4);
      if ((act == 2 && m_cnt >= CL-1) || (act == 4 && m_cnt == CL)) act = 0;
      case (act)
        0: begin shift_image(gen_valid()); do_commit(1'b0); end
        1: begin shift_image(gen_conflict()); do_commit(1'b0); end
        2: begin
          n = $urandom_range(1, CL-1-m_cnt);
          for (int i = 0; i < n; i++) do_shift(1'($urandom_range(0, 1)));
          do_commit(1'b0);
        end
        3: begin shift_image(gen_valid()); do_commit(1'b1); end
        default: do_commit(1'b0);
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
